vector_feeder: RTL and testbench

//  Sequential front-end for the combinational 4-element dot-product unit.
//  - Accepts (a_i, b_i) element pairs one per handshake and assembles them into

---
 rtl/vector_feeder_if.sv | 32 +++
 rtl/vector_feeder.sv | 108 ++++++++++
 tb/tb_vector_feeder.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/vector_feeder_if.sv
// Handshake and datapath bundle between an element source, the vector_feeder
// front-end, the external dot-product unit and the result consumer.
interface vector_feeder_if #(
  parameter int BITS_NUM = 4,
  parameter int ELEM_NUM = 4,
  parameter int RES_W    = 10
);
  // Both handshakes: a transfer completes on a rising clk edge where valid and
  // ready are both high; valid and its payload must hold until that edge.
  logic                         in_valid;
  logic                         in_ready;
  logic [BITS_NUM-1:0]          in_a;
  logic [BITS_NUM-1:0]          in_b;
  logic                         in_last;
  logic [ELEM_NUM*BITS_NUM-1:0] vec_a;
  logic [ELEM_NUM*BITS_NUM-1:0] vec_b;
  logic                         vec_valid;
  logic [RES_W-1:0]             dot_res;
  logic                         out_valid;
  logic                         out_ready;
  logic [RES_W-1:0]             out_data;

  modport slave (
    input  in_valid, in_a, in_b, in_last, dot_res, out_ready,
    output in_ready, vec_a, vec_b, vec_valid, out_valid, out_data
  );

  modport master (
    output in_valid, in_a, in_b, in_last, dot_res, out_ready,
    input  in_ready, vec_a, vec_b, vec_valid, out_valid, out_data
  );
endinterface

// File: rtl/vector_feeder.sv
// Serial-to-parallel front-end for a 4-element dot-product unit: LOAD -> EVAL -> HOLD.
// Optional zero-padded short vectors via in_last when VEC_PAD_EN is defined.
module vector_feeder #(
  parameter int BITS_NUM = 4,
  parameter int ELEM_NUM = 4,
  parameter int RES_W    = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  vector_feeder_if.slave       bus,
  output logic [1:0]           state_o
);

  localparam int IDX_W = (ELEM_NUM > 1) ? $clog2(ELEM_NUM) : 1;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_EVAL = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                       state_q;
  logic [IDX_W-1:0]             idx_q;
  logic [ELEM_NUM*BITS_NUM-1:0] vec_a_q;
  logic [ELEM_NUM*BITS_NUM-1:0] vec_b_q;
  logic [RES_W-1:0]             out_data_q;
  logic                         in_ready_q;
  logic                         vec_valid_q;
  logic                         out_valid_q;
  logic                         accept;
  logic                         final_elem;

  assign accept = bus.in_valid && in_ready_q && (state_q == S_LOAD);

`ifdef VEC_PAD_EN
  // A short vector ends early; untouched slots are still zero from the last clear.
  assign final_elem = (idx_q == IDX_W'(ELEM_NUM - 1)) || bus.in_last;
`else
  logic unused_in_last;
  assign unused_in_last = bus.in_last;
  assign final_elem     = (idx_q == IDX_W'(ELEM_NUM - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LOAD;
      idx_q       <= '0;
      vec_a_q     <= '0;
      vec_b_q     <= '0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b1;
      vec_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (accept) begin
            for (int i = 0; i < ELEM_NUM; i++) begin
              if (idx_q == IDX_W'(i)) begin
                vec_a_q[i*BITS_NUM +: BITS_NUM] <= bus.in_a;
                vec_b_q[i*BITS_NUM +: BITS_NUM] <= bus.in_b;
              end
            end
            if (final_elem) begin
              idx_q       <= '0;
              state_q     <= S_EVAL;
              in_ready_q  <= 1'b0;
              vec_valid_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        S_EVAL: begin
          out_data_q  <= bus.dot_res;
          vec_valid_q <= 1'b0;
          out_valid_q <= 1'b1;
          state_q     <= S_HOLD;
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            vec_a_q     <= '0;
            vec_b_q     <= '0;
            state_q     <= S_LOAD;
          end
        end
        default: begin
          state_q     <= S_LOAD;
          idx_q       <= '0;
          in_ready_q  <= 1'b1;
          vec_valid_q <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.vec_a     = vec_a_q;
  assign bus.vec_b     = vec_b_q;
  assign bus.vec_valid = vec_valid_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_vector_feeder.sv
// Directed bench for vector_feeder; the external dot-product unit is modelled
// combinationally from the vectors the DUT drives.
module tb_vector_feeder;

  localparam int BITS_NUM = 4;
  localparam int ELEM_NUM = 4;
  localparam int RES_W    = 10;
  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_EVAL = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic       clk;
  logic       rst;
  logic [1:0] state;
  int         n_assert;
  int         n_fail;

  vector_feeder_if #(.BITS_NUM(BITS_NUM), .ELEM_NUM(ELEM_NUM), .RES_W(RES_W)) vif ();

  vector_feeder #(.BITS_NUM(BITS_NUM), .ELEM_NUM(ELEM_NUM), .RES_W(RES_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (vif),
    .state_o (state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Dot-product unit model
  always_comb begin
    logic [RES_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < ELEM_NUM; i++)
      acc = acc + RES_W'(vif.vec_a[i*BITS_NUM +: BITS_NUM]) * RES_W'(vif.vec_b[i*BITS_NUM +: BITS_NUM]);
    vif.dot_res = acc;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: offers one pair and waits (bounded) for it to be accepted.
  task automatic send_pair(input logic [3:0] a, input logic [3:0] b, input logic last);
    bit done;
    done        = 1'b0;
    vif.in_valid = 1'b1;
    vif.in_a     = a;
    vif.in_b     = b;
    vif.in_last  = last;
    for (int k = 0; k < 20 && !done; k++) begin
      if (vif.in_ready) done = 1'b1;
      tick();
    end
    if (!done) begin
      n_assert++;
      n_fail++;
      $error("FAIL send_pair_timeout observed=0 expected=1");
    end
    vif.in_valid = 1'b0;
    vif.in_last  = 1'b0;
  endtask

  initial begin
    n_assert      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    vif.in_valid  = 1'b0;
    vif.in_a      = '0;
    vif.in_b      = '0;
    vif.in_last   = 1'b0;
    vif.out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_in_ready", vif.in_ready, 1);
    chk("rst_vec_valid", vif.vec_valid, 0);
    chk("rst_out_valid", vif.out_valid, 0);
    chk("rst_out_data", vif.out_data, 0);
    chk("rst_vec_a", vif.vec_a, 0);
    chk("rst_state", state, ST_LOAD);

    // 1: A=1,2,3,4 B=5,6,7,8 back-to-back, out_ready=1
    send_pair(1, 5, 0);
    send_pair(2, 6, 0);
    send_pair(3, 7, 0);
    send_pair(4, 8, 0);
    chk("t1_state_eval", state, ST_EVAL);
    chk("t1_vec_valid", vif.vec_valid, 1);
    chk("t1_vec_a", vif.vec_a, 32'h4321);
    chk("t1_vec_b", vif.vec_b, 32'h8765);
    chk("t1_out_valid_early", vif.out_valid, 0);
    chk("t1_in_ready_eval", vif.in_ready, 0);
    tick();
    chk("t1_out_valid", vif.out_valid, 1);
    chk("t1_out_data", vif.out_data, 70);
    chk("t1_vec_valid_hold", vif.vec_valid, 0);
    chk("t1_in_ready_hold", vif.in_ready, 0);
    tick();
    chk("t1_out_valid_done", vif.out_valid, 0);
    chk("t1_in_ready_after", vif.in_ready, 1);
    chk("t1_vec_a_cleared", vif.vec_a, 0);

    // 2: all 15s, no truncation
    for (int i = 0; i < 4; i++) send_pair(15, 15, 0);
    tick();
    chk("t2_out_valid", vif.out_valid, 1);
    chk("t2_out_data", vif.out_data, 900);
    tick();
    chk("t2_in_ready_after", vif.in_ready, 1);

    // 3: case 1 with consumer stalled 5 cycles; in_valid during HOLD is ignored
    vif.out_ready = 1'b0;
    send_pair(1, 5, 0);
    send_pair(2, 6, 0);
    send_pair(3, 7, 0);
    send_pair(4, 8, 0);
    vif.in_valid = 1'b1;
    vif.in_a     = 4'd9;
    vif.in_b     = 4'd9;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t3_out_valid_stall", vif.out_valid, 1);
      chk("t3_out_data_stall", vif.out_data, 70);
      chk("t3_in_ready_stall", vif.in_ready, 0);
      chk("t3_vec_a_stall", vif.vec_a, 32'h4321);
      tick();
    end
    vif.in_valid  = 1'b0;
    vif.out_ready = 1'b1;
    tick();
    chk("t3_out_valid_release", vif.out_valid, 0);
    chk("t3_in_ready_release", vif.in_ready, 1);
    chk("t3_state_release", state, ST_LOAD);

    // 4: reset after 2 accepts discards the partial vector
    send_pair(1, 1, 0);
    send_pair(1, 1, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_vec_a_rst", vif.vec_a, 0);
    chk("t4_in_ready_rst", vif.in_ready, 1);
    for (int i = 0; i < 4; i++) send_pair(2, 3, 0);
    chk("t4_vec_a", vif.vec_a, 32'h2222);
    tick();
    chk("t4_out_data", vif.out_data, 24);
    tick();

    // 5: in_valid toggled each cycle; garbage on idle cycles must not load
    for (int k = 0; k < 7; k++) begin
      vif.in_valid = (k % 2 == 0);
      vif.in_a     = (k % 2 == 0) ? 4'(k + 1) : 4'hF;
      vif.in_b     = (k % 2 == 0) ? 4'(k + 2) : 4'hF;
      tick();
      if (k == 4) chk("t5_state_mid", state, ST_LOAD);
    end
    vif.in_valid = 1'b0;
    chk("t5_state_eval", state, ST_EVAL);
    chk("t5_vec_a", vif.vec_a, 32'h7531);
    chk("t5_vec_b", vif.vec_b, 32'h8642);
    tick();
    chk("t5_out_data", vif.out_data, 100);
    tick();

    // 6: short vector with in_last on the 2nd pair
    send_pair(3, 5, 0);
    send_pair(4, 6, 1);
`ifdef VEC_PAD_EN
    chk("t6_state_eval", state, ST_EVAL);
    chk("t6_vec_a", vif.vec_a, 32'h0043);
    chk("t6_vec_b", vif.vec_b, 32'h0065);
    tick();
    chk("t6_out_data", vif.out_data, 39);
    tick();
    chk("t6_in_ready_after", vif.in_ready, 1);
`else
    chk("t6_state_load", state, ST_LOAD);
    chk("t6_in_ready_wait", vif.in_ready, 1);
    chk("t6_out_valid_wait", vif.out_valid, 0);
    send_pair(0, 0, 0);
    send_pair(0, 0, 0);
    chk("t6_state_eval", state, ST_EVAL);
    chk("t6_vec_a", vif.vec_a, 32'h0043);
    tick();
    chk("t6_out_data", vif.out_data, 39);
    tick();
    chk("t6_in_ready_after", vif.in_ready, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
